mem_copy_engine: RTL

- Memory-side initiator that drives the data memory's read/write port: memread, memwrite, 13-bit addr and 16-bit write data.
- Copies a block of words from a source region to a destination region, in direct or pointer-indirect mode.
- Accumulates a 16-bit checksum of the copied words.
- Sits between the controller, which issues start and waits for done, and the single-port data memory.

---
 rtl/mem_copy_engine.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_copy_engine.sv
// Block copy engine driving a single-port data memory: direct or pointer-indirect
// copy of count words from src to dst, with a modulo-2^DW checksum of the words written.
module mem_copy_engine #(
    parameter int AW = 13,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] count,
    output logic          memread,
    output logic          memwrite,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] sum
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_PTR  = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Operands captured at start; the ports are free to change afterwards.
    typedef struct packed {
        logic          mode;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [AW-1:0] cnt;
    } xfer_t;

    state_t        state, state_nxt;
    xfer_t         op;
    logic [AW-1:0] idx;
    logic [AW-1:0] ptr;
    logic [DW-1:0] data_buf;
    logic [DW-1:0] sum_q;
    logic          last;
    logic          rd_en;
    logic          wr_en;

    // count is never 0 once a word is in flight, so count-1 cannot underflow here.
    assign last = (idx == op.cnt - AW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op       <= '0;
            idx      <= '0;
            ptr      <= '0;
            data_buf <= '0;
            sum_q    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        op    <= '{mode: mode, src: src_addr, dst: dst_addr, cnt: count};
                        idx   <= '0;
                        sum_q <= '0;
                    end
                end
                RD_PTR:  ptr      <= mem_rdata[AW-1:0];
                RD_DATA: data_buf <= mem_rdata;
                WR: begin
                    sum_q <= sum_q + data_buf;
                    if (!last) idx <= idx + AW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count == '0) state_nxt = DONE;
                    else if (mode)   state_nxt = RD_PTR;
                    else             state_nxt = RD_DATA;
                end
            end
            RD_PTR:  state_nxt = RD_DATA;
            RD_DATA: state_nxt = WR;
            WR: begin
                if (last)         state_nxt = DONE;
                else if (op.mode) state_nxt = RD_PTR;
                else              state_nxt = RD_DATA;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore decode; address sums are AW wide so they wrap at the top of memory.
    always_comb begin
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        addr      = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            RD_PTR: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                addr  = op.src + idx;
            end
            RD_DATA: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                addr  = op.mode ? ptr : op.src + idx;
            end
            WR: begin
                wr_en     = 1'b1;
                busy      = 1'b1;
                addr      = op.dst + idx;
                mem_wdata = data_buf;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Gating with rst keeps a reset edge from ever landing a write.
    assign memread  = rd_en & ~rst;
    assign memwrite = wr_en & ~rst;
    assign sum      = sum_q;

endmodule
